// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge stage.
// Gradient types are sized for the default 8-bit pixel.
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int GRAD_W   = PIX_W + 3;
    localparam int PIPE_LAT = 3;

    localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
    localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [GRAD_W-1:0] mag_t;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic grad_t pix_ext(input logic [PIX_W-1:0] p);
        return grad_t'({3'b000, p});
    endfunction

    // |g| is at most 1020, so it always fits in mag_t.
    function automatic mag_t abs_grad(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage

// File: rtl/sobel_line_window.sv
// Two line buffers, raster counters, the 3x3 window and the border flag.
// Window outputs and border are valid one clock after the accepted pixel.
module sobel_line_window #(
    parameter int WIDTH = 8,
    parameter int H_RES = 176,
    parameter int V_RES = 144
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] p11,
    output logic [WIDTH-1:0] p12,
    output logic [WIDTH-1:0] p13,
    output logic [WIDTH-1:0] p21,
    output logic [WIDTH-1:0] p22,
    output logic [WIDTH-1:0] p23,
    output logic [WIDTH-1:0] p31,
    output logic [WIDTH-1:0] p32,
    output logic [WIDTH-1:0] p33,
    output logic             border
);

    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);

    logic [WIDTH-1:0] lb0 [0:H_RES-1];
    logic [WIDTH-1:0] lb1 [0:H_RES-1];
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             vsync_q;
    logic             vs_rise;

    assign vs_rise = i_vsync & ~vsync_q;

    // Line buffers: read-before-write, lb1 takes the line lb0 is giving up.
    always_ff @(posedge clk) begin
        if (i_de) begin
            lb0[col] <= i_data;
            lb1[col] <= lb0[col];
        end
    end

    // Raster position; a vsync rising edge restarts the frame ahead of any increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            if (vs_rise) begin
                col <= '0;
                row <= '0;
            end else if (i_de) begin
                if (col == COL_W'(H_RES - 1)) begin
                    col <= '0;
                    if (row != ROW_W'(V_RES - 1))
                        row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Window shifts left on each accepted pixel; border marks incomplete windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            p11 <= '0; p12 <= '0; p13 <= '0;
            p21 <= '0; p22 <= '0; p23 <= '0;
            p31 <= '0; p32 <= '0; p33 <= '0;
            border <= 1'b0;
        end else if (i_de) begin
            p11 <= p12; p12 <= p13; p13 <= lb1[col];
            p21 <= p22; p22 <= p23; p23 <= lb0[col];
            p31 <= p32; p32 <= p33; p33 <= i_data;
            border <= (row < ROW_W'(2)) || (col < COL_W'(2));
        end
    end

endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel edge detector: window -> gradients -> magnitude/threshold, 3-clock latency.
// Build option SOBEL_MAG_OUT_EN: output the saturated magnitude instead of
// the binary edge map (threshold ignored, same latency).
module sobel_edge_detect
    import sobel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int H_RES = 176,
    parameter int V_RES = 144
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH+2:0] i_thresh,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic             border_w;
    logic             border_g;
    grad_t            gx_c, gy_c, gx_q, gy_q;
    mag_t             mag_c;
    logic [PIPE_LAT-1:0] vs_d, hs_d, de_d;

    sobel_line_window #(
        .WIDTH (WIDTH),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .i_vsync (i_vsync),
        .i_de    (i_de),
        .i_data  (i_data),
        .p11     (p11), .p12 (p12), .p13 (p13),
        .p21     (p21), .p22 (p22), .p23 (p23),
        .p31     (p31), .p32 (p32), .p33 (p33),
        .border  (border_w)
    );

    // Sobel kernels on the current window.
    always_comb begin
        gx_c = (pix_ext(p13) + (pix_ext(p23) <<< 1) + pix_ext(p33))
             - (pix_ext(p11) + (pix_ext(p21) <<< 1) + pix_ext(p31));
        gy_c = (pix_ext(p31) + (pix_ext(p32) <<< 1) + pix_ext(p33))
             - (pix_ext(p11) + (pix_ext(p12) <<< 1) + pix_ext(p13));
    end

    // Gradient stage runs every clock; a frozen window just repeats its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q     <= '0;
            gy_q     <= '0;
            border_g <= 1'b0;
        end else begin
            gx_q     <= gx_c;
            gy_q     <= gy_c;
            border_g <= border_w;
        end
    end

    // L1 magnitude, cannot exceed 2040.
    always_comb begin
        mag_c = abs_grad(gx_q) + abs_grad(gy_q);
    end

    // Output pixel: border forces zero, otherwise threshold or saturated magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
        end else if (border_g) begin
            o_data <= EDGE_OFF;
        end else begin
`ifdef SOBEL_MAG_OUT_EN
            o_data <= (mag_c > mag_t'(EDGE_ON)) ? EDGE_ON : mag_c[WIDTH-1:0];
`else
            o_data <= (mag_c >= i_thresh) ? EDGE_ON : EDGE_OFF;
`endif
        end
    end

    // Sync delay line matched to the three data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d <= '0;
            hs_d <= '0;
            de_d <= '0;
        end else begin
            vs_d <= {vs_d[PIPE_LAT-2:0], i_vsync};
            hs_d <= {hs_d[PIPE_LAT-2:0], i_hsync};
            de_d <= {de_d[PIPE_LAT-2:0], i_de};
        end
    end

    assign o_vsync = vs_d[PIPE_LAT-1];
    assign o_hsync = hs_d[PIPE_LAT-1];
    assign o_de    = de_d[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect. Honours SOBEL_MAG_OUT_EN when defined.
module tb_sobel_edge_detect;

    localparam int WIDTH = 8;
    localparam int H_RES = 176;
    localparam int V_RES = 144;

    localparam int K_FLAT  = 0;
    localparam int K_VSTEP = 1;
    localparam int K_VDESC = 2;
    localparam int K_HSTEP = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH+2:0] i_thresh;
    logic             i_vsync, i_hsync, i_de;
    logic [WIDTH-1:0] i_data;
    logic             o_vsync, o_hsync, o_de;
    logic [WIDTH-1:0] o_data;

    int passed = 0;
    int total  = 0;
    logic [7:0] outq[$];

    always #5 clk = ~clk;

    sobel_edge_detect #(.WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_thresh (i_thresh),
        .i_vsync  (i_vsync),
        .i_hsync  (i_hsync),
        .i_de     (i_de),
        .i_data   (i_data),
        .o_vsync  (o_vsync),
        .o_hsync  (o_hsync),
        .o_de     (o_de),
        .o_data   (o_data)
    );

    always @(negedge clk) begin
        if (o_de === 1'b1) outq.push_back(o_data);
    end

    // Source image: steps at column 80 or row 3.
    function automatic logic [7:0] pix(input int kind, input int amp, input int r, input int c);
        case (kind)
            K_VSTEP: return (c >= 80) ? 8'(amp) : 8'd0;
            K_VDESC: return (c >= 80) ? 8'd0 : 8'(amp);
            K_HSTEP: return (r >= 3) ? 8'(amp) : 8'd0;
            default: return 8'(amp);
        endcase
    endfunction

    // Expected output for input position (r,c); a step of amp gives magnitude 4*amp
    // at the two window positions straddling it.
    function automatic logic [7:0] exp_px(input int kind, input int amp, input int r,
                                          input int c, input int thr);
        int mag;
        mag = 0;
        if (kind == K_VSTEP || kind == K_VDESC) mag = (c == 80 || c == 81) ? 4 * amp : 0;
        if (kind == K_HSTEP) mag = (r == 3 || r == 4) ? 4 * amp : 0;
        if (r < 2 || c < 2) return 8'h00;
`ifdef SOBEL_MAG_OUT_EN
        return (mag > 255) ? 8'hFF : 8'(mag);
`else
        return (mag >= thr) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [7:0] d);
        i_de   = 1'b1;
        i_data = d;
        tick();
        i_de   = 1'b0;
    endtask

    task automatic start_frame();
        i_de = 1'b0;
        i_vsync = 1'b1;
        tick();
        tick();
        i_vsync = 1'b0;
        tick();
    endtask

    task automatic flush();
        i_de = 1'b0;
        repeat (6) tick();
    endtask

    task automatic send_rows(input int kind, input int amp, input int nrows, input bit gaps);
        for (int r = 0; r < nrows; r++) begin
            i_hsync = 1'b1;
            tick();
            i_hsync = 1'b0;
            tick();
            for (int c = 0; c < H_RES; c++) begin
                if (gaps) begin
                    int g;
                    g = $urandom_range(0, 2);
                    for (int k = 0; k < g; k++) begin
                        i_de = 1'b0;
                        i_data = 8'($urandom);
                        tick();
                    end
                end
                send_px(pix(kind, amp, r, c));
            end
        end
    endtask

    task automatic check_rows(input string name, input int kind, input int amp,
                              input int nrows, input int thr);
        total++;
        if (outq.size() != nrows * H_RES) begin
            $display("FAIL %s o_de count: got %0d expected %0d", name, outq.size(), nrows * H_RES);
        end else begin
            passed++;
            for (int r = 0; r < nrows; r++) begin
                for (int c = 0; c < H_RES; c++) begin
                    logic [7:0] e, g;
                    e = exp_px(kind, amp, r, c, thr);
                    g = outq[r * H_RES + c];
                    total++;
                    if (g !== e)
                        $display("FAIL %s pixel r%0d c%0d: got %h expected %h", name, r, c, g, e);
                    else
                        passed++;
                end
            end
        end
    endtask

    task automatic run_image(input string name, input int kind, input int amp, input int thr,
                             input int nrows, input bit gaps);
        i_thresh = 11'(thr);
        start_frame();
        outq.delete();
        send_rows(kind, amp, nrows, gaps);
        flush();
        check_rows(name, kind, amp, nrows, thr);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_thresh = 11'd1; i_vsync = 1'b1; i_hsync = 1'b1; i_de = 1'b1; i_data = 8'hAA;
        repeat (3) tick();
        total++;
        if ({o_vsync, o_hsync, o_de} !== 3'b000) $display("FAIL reset syncs: got %b expected 000", {o_vsync, o_hsync, o_de});
        else passed++;
        total++;
        if (o_data !== 8'h00) $display("FAIL reset o_data: got %h expected 00", o_data);
        else passed++;
        rst = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic test_latency_sync();
        logic [2:0] exp_s [4];
        exp_s[0] = 3'b000; exp_s[1] = 3'b101; exp_s[2] = 3'b010; exp_s[3] = 3'b000;
        repeat (4) tick();
        i_de = 1'b1; i_vsync = 1'b1; i_hsync = 1'b0; i_data = 8'h00;
        tick();
        i_de = 1'b0; i_vsync = 1'b0; i_hsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            i_hsync = 1'b0;
            total++;
            if ({o_vsync, o_hsync, o_de} !== exp_s[i])
                $display("FAIL latency step %0d {vs,hs,de}: got %b expected %b", i, {o_vsync, o_hsync, o_de}, exp_s[i]);
            else
                passed++;
        end
        flush();
    endtask

    task automatic test_flat_frame();
        int nz;
        i_thresh = 11'd1;
        start_frame();
        outq.delete();
        send_rows(K_FLAT, 100, V_RES, 1'b0);
        flush();
        total++;
        if (outq.size() != H_RES * V_RES) $display("FAIL flat o_de count: got %0d expected %0d", outq.size(), H_RES * V_RES);
        else passed++;
        nz = 0;
        foreach (outq[i]) if (outq[i] !== 8'h00) nz++;
        total++;
        if (nz != 0) $display("FAIL flat nonzero pixels: got %0d expected 0", nz);
        else passed++;
    endtask

    task automatic test_steps();
        run_image("vstep", K_VSTEP, 200, 128, 4, 1'b0);
        run_image("vdesc", K_VDESC, 200, 128, 3, 1'b0);
        run_image("hstep", K_HSTEP, 200, 128, 6, 1'b0);
    endtask

    task automatic test_threshold_boundary();
        run_image("thr64", K_VSTEP, 16, 64, 3, 1'b0);
        run_image("thr65", K_VSTEP, 16, 65, 3, 1'b0);
    endtask

    task automatic test_random_gaps();
        run_image("gaps", K_VSTEP, 200, 128, 4, 1'b1);
    endtask

    task automatic test_vsync_mid_frame();
        i_thresh = 11'd1;
        start_frame();
        send_rows(K_FLAT, 200, 50, 1'b0);
        for (int c = 0; c < 30; c++) send_px(8'd200);
        i_vsync = 1'b1;
        tick();
        i_vsync = 1'b0;
        tick();
        flush();
        outq.delete();
        send_rows(K_FLAT, 0, 3, 1'b0);
        flush();
        check_rows("vsync_mid", K_FLAT, 0, 3, 1);
    endtask

    task automatic test_rst_mid_line();
        i_thresh = 11'd128;
        start_frame();
        send_rows(K_HSTEP, 200, 4, 1'b0);
        i_hsync = 1'b1; tick(); i_hsync = 1'b0; tick();
        for (int c = 0; c < 60; c++) begin
            i_hsync = (c >= 57);
            send_px(pix(K_HSTEP, 200, 4, c));
        end
        total++;
        if ({o_de, o_hsync, o_data} !== {1'b1, 1'b1, 8'hFF})
            $display("FAIL pre_rst outputs {de,hs,data}: got %b %b %h expected 1 1 ff", o_de, o_hsync, o_data);
        else passed++;
        rst = 1'b1; i_de = 1'b1; i_vsync = 1'b1; i_hsync = 1'b1; i_data = 8'd200;
        tick();
        total++;
        if ({o_vsync, o_hsync, o_de} !== 3'b000) $display("FAIL rst_mid syncs: got %b expected 000", {o_vsync, o_hsync, o_de});
        else passed++;
        total++;
        if (o_data !== 8'h00) $display("FAIL rst_mid o_data: got %h expected 00", o_data);
        else passed++;
        rst = 1'b0; i_de = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0; i_data = 8'h00;
        tick();
        outq.delete();
        i_thresh = 11'd1;
        send_rows(K_FLAT, 0, 3, 1'b0);
        flush();
        check_rows("rst_mid", K_FLAT, 0, 3, 1);
    endtask

    initial begin
        test_reset();
        test_latency_sync();
        test_flat_frame();
        test_steps();
        test_threshold_boundary();
        test_random_gaps();
        test_vsync_mid_frame();
        test_rst_mid_line();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
